// File: rtl/count_sequencer.sv
// count_sequencer: start/stop/pause run controller driving a registered 0..limit step count (DOWN_COUNT_EN adds dir for down-counting)
module count_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEFAULT_LIMIT = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
`ifdef DOWN_COUNT_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, lim_q, lim_d, start_cnt, reload, step;
  logic mode_q, mode_d, busy_q, done_q, done_d, wrap_q, wrap_d, dir_q, term;
`ifdef DOWN_COUNT_EN
  always_ff @(posedge clock) dir_q <= reset ? 1'b0 : (state_q == IDLE && start) ? dir : dir_q;
  assign start_cnt = dir ? limit : '0;
`else
  assign dir_q = 1'b0;
  assign start_cnt = '0;
`endif
  assign term = dir_q ? cnt_q == '0 : cnt_q == lim_q;
  assign reload = dir_q ? lim_q : '0;
  assign step = dir_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lim_d = lim_q;
    mode_d = mode_q;
    done_d = 1'b0;
    wrap_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        lim_d = limit;
        mode_d = mode;
        cnt_d = start_cnt;
      end
    end else if (stop) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == PAUSE) begin
      state_d = pause ? PAUSE : RUN;
    end else if (pause) begin
      state_d = PAUSE;
    end else if (term && !mode_q) begin
      state_d = IDLE;
      done_d = 1'b1;
    end else if (term) begin
      cnt_d = reload;
      wrap_d = 1'b1;
    end else begin
      cnt_d = step;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lim_q <= WIDTH'(DEFAULT_LIMIT);
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      mode_q <= mode_d;
      busy_q <= state_d != IDLE;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end
  assign count = cnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;
endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Run controller for the team's wrap-around step counter. It accepts start/stop/pause commands and drives a WIDTH-bit count from 0 to a programmable terminal value, either once (one-shot) or repeatedly (continuous). It reports busy status, emits a done pulse and a wrap pulse, and sits between control logic and any consumer of the step index. The default limit of 10 reproduces the existing 0..10 repeating sequence.

Parameters:
WIDTH, 4, width of count and limit.
DEFAULT_LIMIT, 10, terminal value loaded at reset; used only for lim_q reset value.

Ports:
clock  input  1  rising-edge clock, sole clock domain
reset  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
stop  input  1  abort a run; sampled in RUN/PAUSE
pause  input  1  level; freezes count while high in RUN/PAUSE
mode  input  1  0 = one-shot, 1 = continuous; latched at start
limit  input  WIDTH  terminal count; latched at start
count  output  WIDTH  current step index (registered)
busy  output  1  high in RUN and PAUSE
done  output  1  one-cycle pulse at one-shot completion
wrap  output  1  one-cycle pulse when continuous run returns to 0

Behaviour:
- Interface: one clock (clock). Reset is synchronous and active-high (reset).
- All outputs are registered. Reset gives: state IDLE, count 0, busy 0, done 0, wrap 0, lim_q DEFAULT_LIMIT, mode_q 0. Reset has top priority, including mid-run.
- States: IDLE, RUN, PAUSE.
- IDLE:
  - count holds its last value.
  - start=1: lim_q <= limit, mode_q <= mode, count <= 0, go to RUN, busy=1 from the next cycle.
  - stop is ignored in IDLE, so start wins if start and stop arrive together.
- RUN, priority order stop > pause > terminal > increment:
  - stop: go to IDLE, count <= 0, busy 0, no done or wrap pulse.
  - pause: go to PAUSE, count holds.
  - count==lim_q with mode_q=0: go to IDLE, count holds lim_q, done=1 for one cycle, busy 0.
  - count==lim_q with mode_q=1: count <= 0, wrap=1 for one cycle, stay in RUN.
  - otherwise: count <= count+1, with modulo 2^WIDTH arithmetic. lim_q=2^WIDTH-1 is legal.
- PAUSE:
  - stop: same as in RUN.
  - pause=0: return to RUN with no count change on that edge. Incrementing resumes on the following edge.
  - pause=1: hold.
- start is ignored in RUN and PAUSE. Changes on limit and mode mid-run have no effect.
- done and wrap are 0 on every cycle except the one pulse cycle. They are never high together.
- limit=0, one-shot: count=0 for one RUN cycle, then done. Latency from the start edge to the done-high edge is 1 cycle.
- limit=0, continuous: count stays 0 and wrap is high on every RUN cycle.
- One-shot run length: lim_q+1 RUN cycles, plus the number of cycles spent paused.

Optional Feature:
DOWN_COUNT_EN
- Defined:
  - Adds an input port dir (1 bit), latched at start as dir_q.
  - dir_q=1: count <= lim_q at start, decrements each RUN cycle, and the terminal condition is count==0.
  - Continuous down mode reloads lim_q and pulses wrap.
  - Stop still clears count to 0.
  - dir_q=0 behaves exactly as the undefined build.
- Undefined: no dir port and up-count only. Everything else is identical.

Test Plan:
- Reset 2 cycles, then idle -> count=0, busy=0, done=0, wrap=0. Assert reset mid-run at count=5 -> count=0, busy=0 on the next edge.
- start with limit=10, mode=1, held 25 cycles -> count 0..10,0..10,0,1,2; wrap high exactly when count returns to 0 (twice); done never high.
- start with limit=3, mode=0 -> count 0,1,2,3; done high one cycle after count=3; busy falls with done; count holds 3. A second start then restarts from 0.
- One-shot limit=7; pause high at count=4 for 3 cycles; stop at count=6 -> count frozen at 4 for 3 cycles then 5,6; after stop, count=0, busy=0, no done.
- start+stop same cycle in IDLE with limit=0, mode=0 -> RUN entered, count=0; done one cycle later. Changing limit to 9 mid-run has no effect.
- DOWN_COUNT_EN defined, dir=1, limit=5, continuous -> count 5,4,3,2,1,0,5; wrap on the reload to 5.
